mem_stream_reader: RTL and testbench

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_rd_pkg.sv | 14 +
 rtl/mem_rd_skid.sv | 58 +++++
 rtl/mem_stream_reader.sv | 146 ++++++++++++++
 tb/tb_mem_stream_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared constants and state encoding for the memory stream reader.
package mem_rd_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int LEN_W      = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/mem_rd_skid.sv
// Two-entry output buffer for read data.
// It can push and pop in the same cycle, including when it is full.
module mem_rd_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_W-1:0] data_q;
            logic              last_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    last_q <= 1'b0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    data_q <= push_data;
                    last_q <= push_last;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    // An empty buffer presents zero data, so idle outputs stay quiet.
    assign head_valid = (cnt_q != 2'd0);
    assign head_data  = !head_valid ? '0
                      : (rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q);
    assign head_last  = head_valid & (rd_ptr_q ? g_entry[1].last_q : g_entry[0].last_q);
    assign count      = cnt_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: it reads length words starting at base_addr and streams them out with backpressure.
// The running sum of beats is built only when MEM_STREAM_READER_SUM_EN is defined.
module mem_stream_reader
    import mem_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          length,
    output logic                     busy,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] sum
);

    localparam int LW = ADDR_W + 1;
    localparam int SW = DATA_W + ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
    logic [ADDR_W:0]   left_q, left_d, len_c;
    logic              inflight_q, inflight_last_q;
    logic              done_q, done_d;
    logic              rd_en, rd_last, fire, start_ok;
    logic [DATA_W-1:0] sk_data;
    logic              sk_valid, sk_last;
    logic [1:0]        occ;
    logic [2:0]        proj;

    mem_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (mem_rdata),
        .push_last  (inflight_last_q),
        .pop        (fire),
        .head_data  (sk_data),
        .head_last  (sk_last),
        .head_valid (sk_valid),
        .count      (occ)
    );

    assign len_c    = (length > MAX_LEN) ? MAX_LEN : length;
    assign start_ok = start && (state_q == IDLE);
    assign fire     = out_valid && out_ready;
    // The buffer occupancy after this cycle's pop and pending capture must leave room for a new read.
    assign proj     = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, fire};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        rd_en   = 1'b0;
        rd_last = 1'b0;
        rd_addr = addr_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                rd_addr = '0;
                if (start) begin
                    if (len_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // The first read goes out on the start cycle so data is visible two cycles later.
                        rd_en   = 1'b1;
                        rd_addr = base_addr;
                        rd_last = (len_c == LW'(1));
                        addr_d  = base_addr + ADDR_W'(1);
                        left_d  = len_c - LW'(1);
                        state_d = (len_c == LW'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (proj < 3'd2) begin
                    rd_en   = 1'b1;
                    rd_last = (left_q == LW'(1));
                    addr_d  = addr_q + ADDR_W'(1);
                    left_d  = left_q - LW'(1);
                    if (left_q == LW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fire && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            left_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            left_q          <= left_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en & rd_last;
            done_q          <= done_d;
        end
    end

    assign mem_rd_en = rd_en & ~rst;
    assign mem_addr  = rst ? '0 : rd_addr;
    assign out_valid = sk_valid & ~rst;
    assign out_last  = sk_last & ~rst;
    assign out_data  = rst ? '0 : sk_data;
    assign done      = done_q & ~rst;
    assign busy      = ((state_q != IDLE) | done_q) & ~rst;

`ifdef MEM_STREAM_READER_SUM_EN
    logic [SW-1:0] sum_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (fire) begin
            sum_q <= sum_q + SW'(out_data);
        end
    end
    assign sum = sum_q;
`else
    assign sum = '0;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomised self-checking bench for mem_stream_reader with a queue-based burst reference model.
// The expected sum follows MEM_STREAM_READER_SUM_EN, and the port stays at zero when the macro is undefined.
module tb_mem_stream_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int SW = DW + AW;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [AW-1:0]               base_addr;
    logic [mem_rd_pkg::LEN_W-1:0] length;
    logic                        busy, mem_rd_en, out_valid, out_ready, out_last, done;
    logic [AW-1:0]               mem_addr;
    logic [DW-1:0]               mem_rdata, out_data;
    logic [SW-1:0]               sum;

    logic [DW-1:0] mem [16];
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            chain_pending = 1'b0;
    logic [SW-1:0] chain_sum;

    always #5 clk = ~clk;

    mem_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done),
        .sum       (sum)
    );

    // Synchronous-read memory: data follows the read strobe by one cycle.
    initial mem_rdata = '0;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    function automatic logic [SW-1:0] sum_model(input logic [SW-1:0] s);
`ifdef MEM_STREAM_READER_SUM_EN
        return s;
`else
        return '0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; base_addr = 4'd5; length = 5'd3; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, mem_rd_en, out_valid, out_last, done} !== 5'b0 || mem_addr !== '0
            || out_data !== '0 || sum !== '0)
            $display("FAIL reset_state: busy=%b rd=%b vld=%b last=%b done=%b addr=%0d data=%0d sum=%0d, required all 0",
                     busy, mem_rd_en, out_valid, out_last, done, mem_addr, out_data, sum);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        n_checks++;
        if ({busy, mem_rd_en, out_valid, done} !== 4'b0)
            $display("FAIL reset_start_priority: busy=%b rd=%b vld=%b done=%b, required 0", busy, mem_rd_en, out_valid, done);
        else n_pass++;
        $display("reset: idle after release");
    endtask

    // One burst: drive start, run until done (or until the last beat when chain_out is set), then compare with the model.
    task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len, input int rmode,
                             input int stray_cyc, input bit chain_out, input string name);
        logic [DW-1:0] exp_d [$];
        logic [DW-1:0] got_d [$];
        logic [AW-1:0] exp_a [$];
        logic [AW-1:0] got_a [$];
        logic [AW-1:0] a;
        logic [SW-1:0] exp_sum, sum_at_done;
        logic [DW-1:0] prev_d;
        logic          prev_l, busy_at_done, busy_after;
        bit            prev_stall, finished, chain_in, ok;
        int            n, cyc, first_v, done_cyc, done_cnt, last_cnt, last_idx, stable_err;
        n = (len > 5'd16) ? 16 : int'(len);
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            exp_a.push_back(a);
            exp_d.push_back(mem[a]);
            exp_sum += SW'(mem[a]);
        end
        chain_in = chain_pending; chain_pending = 1'b0;
        cyc = 0; first_v = -1; done_cyc = -1; done_cnt = 0; last_cnt = 0; last_idx = -1;
        stable_err = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0; finished = 1'b0;
        sum_at_done = '0; busy_at_done = 1'b0; busy_after = 1'b1;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            start     = (cyc == 0) || (cyc == stray_cyc);
            base_addr = (cyc == 0) ? base : 4'd9;
            length    = (cyc == 0) ? len : 5'd3;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (cyc == 0 && chain_in) begin
                n_checks++;
                if (done !== 1'b1 || sum !== chain_sum)
                    $display("FAIL %s b2b_prev_done: done=%b sum=%0d, required done=1 sum=%0d", name, done, sum, chain_sum);
                else n_pass++;
            end
            if (mem_rd_en) got_a.push_back(mem_addr);
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (prev_stall && (out_data !== prev_d || out_last !== prev_l)) stable_err++;
                if (out_ready) begin
                    got_d.push_back(out_data);
                    if (out_last) begin last_cnt++; last_idx = got_d.size(); end
                    if (chain_out && got_d.size() == n) finished = 1'b1;
                end
                prev_stall = !out_ready; prev_d = out_data; prev_l = out_last;
            end else begin
                prev_stall = 1'b0;
            end
            if (done && !(cyc == 0 && chain_in)) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; sum_at_done = sum; busy_at_done = busy; end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin busy_after = busy; finished = 1'b1; end
            cyc++;
        end
        start = 1'b0;

        n_checks++;
        if (!finished) $display("FAIL %s timeout: ran %0d cycles, required completion within 200", name, cyc);
        else n_pass++;

        ok = (got_d.size() == n);
        for (int i = 0; i < n && ok; i++) if (got_d[i] !== exp_d[i]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL %s beats: got %0d beats (first %0d), required %0d beats (first %0d)", name,
                          got_d.size(), (got_d.size() > 0) ? got_d[0] : 0, n, (n > 0) ? exp_d[0] : 0);
        else n_pass++;

        ok = (got_a.size() == n);
        for (int i = 0; i < n && ok; i++) if (got_a[i] !== exp_a[i]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL %s read_addrs: got %0d reads (first %0d), required %0d reads from %0d", name,
                          got_a.size(), (got_a.size() > 0) ? got_a[0] : 0, n, base);
        else n_pass++;

        n_checks++;
        if ((n > 0 && (last_cnt != 1 || last_idx != n)) || (n == 0 && last_cnt != 0))
            $display("FAIL %s out_last: seen %0d times at beat %0d, required once at beat %0d", name, last_cnt, last_idx, n);
        else n_pass++;

        n_checks++;
        if (first_v != ((n > 0) ? 2 : -1))
            $display("FAIL %s first_valid: cycle %0d, required %0d", name, first_v, (n > 0) ? 2 : -1);
        else n_pass++;

        if (rmode != 0) begin
            n_checks++;
            if (stable_err != 0) $display("FAIL %s stall_stable: %0d changes while stalled, required 0", name, stable_err);
            else n_pass++;
        end

        if (chain_out) begin
            chain_pending = 1'b1;
            chain_sum = sum_model(exp_sum);
        end else begin
            n_checks++;
            if (done_cnt != 1 || busy_at_done !== 1'b1 || busy_after !== 1'b0)
                $display("FAIL %s done: pulses=%0d busy_at_done=%b busy_after=%b, required 1/1/0", name,
                         done_cnt, busy_at_done, busy_after);
            else n_pass++;
            n_checks++;
            if (sum_at_done !== sum_model(exp_sum))
                $display("FAIL %s sum: got %0d, required %0d", name, sum_at_done, sum_model(exp_sum));
            else n_pass++;
            if (rmode == 0) begin
                n_checks++;
                if (done_cyc != ((n == 0) ? 1 : n + 2))
                    $display("FAIL %s done_cycle: %0d, required %0d", name, done_cyc, (n == 0) ? 1 : n + 2);
                else n_pass++;
            end
        end
        $display("burst %s: base=%0d len=%0d beats=%0d done_cycle=%0d", name, base, len, got_d.size(), done_cyc);
    endtask

    task automatic test_basic();
        run_burst(4'd3, 5'd4, 0, -1, 1'b0, "basic");
    endtask

    task automatic test_wrap();
        run_burst(4'd14, 5'd4, 0, -1, 1'b0, "wrap");
    endtask

    task automatic test_backpressure();
        run_burst(4'd0, 5'd16, 1, -1, 1'b0, "toggle16");
    endtask

    task automatic test_length_bounds();
        run_burst(4'd6, 5'd0, 0, -1, 1'b0, "len0");
        run_burst(4'd5, 5'd20, 0, -1, 1'b0, "len20");
        run_burst(4'd11, 5'd1, 0, -1, 1'b0, "len1");
    endtask

    task automatic test_start_while_busy();
        run_burst(4'd2, 5'd6, 0, 3, 1'b0, "stray_start");
    endtask

    task automatic test_back_to_back();
        run_burst(4'd7, 5'd3, 0, -1, 1'b1, "b2b_a");
        run_burst(4'd10, 5'd5, 0, -1, 1'b0, "b2b_b");
    endtask

    task automatic test_reset_mid();
        int beats;
        bit quiet;
        beats = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = (c == 0); base_addr = 4'd8; length = 5'd8; out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) beats++;
        end
        start = 1'b0;
        n_checks++;
        if (beats != 2) $display("FAIL rst_mid_pre: %0d beats before reset, required 2", beats);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || done !== 1'b0)
            $display("FAIL rst_mid_after: vld=%b busy=%b sum=%0d done=%b, required 0/0/0/0", out_valid, busy, sum, done);
        else n_pass++;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (done || out_valid || mem_rd_en || busy) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) $display("FAIL rst_mid_quiet: activity after aborted burst, required none");
        else n_pass++;
        $display("reset mid-burst: %0d beats before abort", beats);
        run_burst(4'd1, 5'd5, 2, -1, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        for (int k = 0; k < 8; k++)
            run_burst(AW'($urandom_range(0, 15)), 5'($urandom_range(0, 20)), 2, -1, 1'b0, "random");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(i + 1);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_length_bounds();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
